// File: rtl/fft_pkg.sv
// Shared constants and types for the FFT post-processing stages.
package fft_pkg;

  localparam int unsigned FFTPTS_W = 11;
  localparam int unsigned BIN_W    = 10;

  // Avalon-ST error codes produced by the FFT core
  localparam logic [1:0] ERR_NONE           = 2'b00;
  localparam logic [1:0] ERR_MISSING_SOP    = 2'b01;
  localparam logic [1:0] ERR_MISSING_EOP    = 2'b10;
  localparam logic [1:0] ERR_UNEXPECTED_EOP = 2'b11;

  typedef enum logic [0:0] {
    StIdle,
    StInFrame
  } frame_state_e;

endpackage

// File: rtl/fft_bin_power_sq.sv
// Two-stage signed square-and-sum: stage 1 squares, stage 2 adds.
module fft_bin_power_sq #(
  parameter int unsigned IN_W = 29
) (
  input  logic                   clk,
  input  logic                   en,
  input  logic signed [IN_W-1:0] re,
  input  logic signed [IN_W-1:0] im,
  output logic [2*IN_W-1:0]      sum
);

  logic signed [2*IN_W-1:0] sq_re_q, sq_im_q;
  logic        [2*IN_W-1:0] sum_q;

  // Operands are sign-extended to 2*IN_W before multiplying, so the
  // most negative input squares exactly.
  always_ff @(posedge clk) begin
    if (en) begin
      sq_re_q <= re * re;
      sq_im_q <= im * im;
      sum_q   <= $unsigned(sq_re_q) + $unsigned(sq_im_q);
    end
  end

  assign sum = sum_q;

endmodule

// File: rtl/fft_bin_power.sv
// Streaming power-spectrum stage: re^2 + im^2 per bin, scaled, saturated,
// tagged with the bin index, with frame checking on the FFT output stream.
module fft_bin_power
  import fft_pkg::*;
#(
  parameter int unsigned IN_W  = 29,
  parameter int unsigned OUT_W = 32,
  parameter int unsigned SHIFT = 26
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   sink_valid,
  output logic                   sink_ready,
  input  logic [1:0]             sink_error,
  input  logic                   sink_sop,
  input  logic                   sink_eop,
  input  logic signed [IN_W-1:0] sink_real,
  input  logic signed [IN_W-1:0] sink_imag,
  input  logic [FFTPTS_W-1:0]    fftpts_in,
  output logic                   source_valid,
  input  logic                   source_ready,
  output logic                   source_sop,
  output logic                   source_eop,
  output logic [1:0]             source_error,
  output logic [OUT_W-1:0]       source_power,
  output logic [BIN_W-1:0]       source_bin,
  output logic                   frame_err,
  output logic [7:0]             err_count
);

  localparam int unsigned PW = 2 * IN_W;
  localparam int unsigned WW = (PW > OUT_W) ? PW : OUT_W;

  logic adv, acc;
  assign adv        = !source_valid || source_ready;
  assign sink_ready = adv;
  assign acc        = sink_valid && adv;

  frame_state_e         state_q, state_d;
  logic [BIN_W-1:0]     bin_q, bin_d, beat_bin;
  logic [FFTPTS_W-1:0]  pts_q, pts_d;
  logic                 fwd, viol, force_eop, last_bin;

  assign last_bin = (FFTPTS_W'(bin_q) == pts_q - FFTPTS_W'(1));

  always_ff @(posedge clk) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bin_q <= '0;
      pts_q <= '0;
    end else begin
      bin_q <= bin_d;
      pts_q <= pts_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (acc) begin
      case (state_q)
        StIdle:    if (sink_sop && !sink_eop) state_d = StInFrame;
        StInFrame: begin
          if (sink_sop)                   state_d = sink_eop ? StIdle : StInFrame;
          else if (sink_eop || last_bin)  state_d = StIdle;
        end
        default:   state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    fwd       = 1'b0;
    viol      = 1'b0;
    force_eop = 1'b0;
    beat_bin  = bin_q;
    bin_d     = bin_q;
    pts_d     = pts_q;
    if (acc) begin
      if (sink_sop) begin
        // A sop always restarts the frame, even when it interrupts one
        fwd      = 1'b1;
        viol     = (state_q == StInFrame) || sink_eop;
        beat_bin = '0;
        bin_d    = BIN_W'(1);
        pts_d    = fftpts_in;
      end else if (state_q == StIdle) begin
        viol = 1'b1;
      end else begin
        fwd       = 1'b1;
        bin_d     = bin_q + BIN_W'(1);
        viol      = (sink_eop != last_bin);
        force_eop = last_bin && !sink_eop;
      end
    end
  end

  // Sideband pipeline alongside the two square/sum stages
  logic             s1_valid, s2_valid;
  logic             s1_sop, s1_eop, s2_sop, s2_eop;
  logic [1:0]       s1_err, s2_err;
  logic [BIN_W-1:0] s1_bin, s2_bin;
  logic [PW-1:0]    sq_sum;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else if (adv) begin
      s1_valid <= acc && fwd;
      s2_valid <= s1_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (adv) begin
      s1_sop <= sink_sop;
      s1_eop <= sink_eop || force_eop;
      s1_err <= sink_error;
      s1_bin <= beat_bin;
      s2_sop <= s1_sop;
      s2_eop <= s1_eop;
      s2_err <= s1_err;
      s2_bin <= s1_bin;
    end
  end

  fft_bin_power_sq #(
    .IN_W (IN_W)
  ) u_sq (
    .clk (clk),
    .en  (adv),
    .re  (sink_real),
    .im  (sink_imag),
    .sum (sq_sum)
  );

  logic [WW-1:0]    shifted;
  logic             sat;
  logic [OUT_W-1:0] power_d;

  assign shifted = WW'(sq_sum) >> SHIFT;
  assign sat     = (shifted >> OUT_W) != '0;
  assign power_d = sat ? '1 : shifted[OUT_W-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      source_valid <= 1'b0;
      source_sop   <= 1'b0;
      source_eop   <= 1'b0;
      source_error <= ERR_NONE;
      source_power <= '0;
      source_bin   <= '0;
    end else if (adv) begin
      source_valid <= s2_valid;
      source_sop   <= s2_sop;
      source_eop   <= s2_eop;
      source_error <= s2_err;
      source_power <= power_d;
      source_bin   <= s2_bin;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      frame_err <= 1'b0;
      err_count <= '0;
    end else begin
      frame_err <= viol;
      if (viol && err_count != 8'hFF) err_count <= err_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_fft_bin_power.sv
// Self-checking bench for fft_bin_power: a frame-rule model predicts every
// output beat, error pulse and count; two instances cover SHIFT=26 and SHIFT=0.
module tb_fft_bin_power;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic               sink_valid = 1'b0, sink_sop = 1'b0, sink_eop = 1'b0;
  logic [1:0]         sink_error = '0;
  logic signed [28:0] sink_real = '0, sink_imag = '0;
  logic [10:0]        fftpts_in = '0;
  logic               source_ready = 1'b1;

  logic        sink_ready, source_valid, source_sop, source_eop, frame_err;
  logic [1:0]  source_error;
  logic [31:0] source_power;
  logic [9:0]  source_bin;
  logic [7:0]  err_count;

  logic        sink_ready_z, source_valid_z, source_sop_z, source_eop_z, frame_err_z;
  logic [1:0]  source_error_z;
  logic [31:0] source_power_z;
  logic [9:0]  source_bin_z;
  logic [7:0]  err_count_z;

  fft_bin_power dut (
    .clk (clk), .reset (reset),
    .sink_valid (sink_valid), .sink_ready (sink_ready), .sink_error (sink_error),
    .sink_sop (sink_sop), .sink_eop (sink_eop),
    .sink_real (sink_real), .sink_imag (sink_imag), .fftpts_in (fftpts_in),
    .source_valid (source_valid), .source_ready (source_ready),
    .source_sop (source_sop), .source_eop (source_eop), .source_error (source_error),
    .source_power (source_power), .source_bin (source_bin),
    .frame_err (frame_err), .err_count (err_count)
  );

  fft_bin_power #(.SHIFT(0)) dut_s0 (
    .clk (clk), .reset (reset),
    .sink_valid (sink_valid), .sink_ready (sink_ready_z), .sink_error (sink_error),
    .sink_sop (sink_sop), .sink_eop (sink_eop),
    .sink_real (sink_real), .sink_imag (sink_imag), .fftpts_in (fftpts_in),
    .source_valid (source_valid_z), .source_ready (source_ready),
    .source_sop (source_sop_z), .source_eop (source_eop_z), .source_error (source_error_z),
    .source_power (source_power_z), .source_bin (source_bin_z),
    .frame_err (frame_err_z), .err_count (err_count_z)
  );

  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        sop, eop;
    logic [1:0]  err;
    logic [9:0]  bin;
    logic [31:0] p_def, p_s0;
  } beat_t;
  beat_t expq[$];

  function automatic logic [31:0] scale(input logic signed [28:0] re, input logic signed [28:0] im,
                                        input int sh);
    logic [63:0] p;
    p = 64'(longint'(re) * longint'(re)) + 64'(longint'(im) * longint'(im));
    p = p >> sh;
    if (p > 64'hFFFF_FFFF) return 32'hFFFF_FFFF;
    return p[31:0];
  endfunction

  // Frame-rule model state
  bit m_in_frame = 0, m_ferr = 0;
  int m_bin = 0, m_pts = 0, m_cnt = 0;

  task model_accept();
    bit    viol, fwd;
    beat_t b;
    viol  = 0;
    fwd   = 0;
    b.sop = sink_sop;
    b.eop = sink_eop;
    b.err = sink_error;
    b.p_def = scale(sink_real, sink_imag, 26);
    b.p_s0  = scale(sink_real, sink_imag, 0);
    b.bin = '0;
    if (sink_sop) begin
      viol  = m_in_frame || sink_eop;
      m_pts = int'(fftpts_in);
      fwd   = 1;
      m_in_frame = !sink_eop;
      m_bin = 1;
    end else if (!m_in_frame) begin
      viol = 1;
    end else begin
      fwd   = 1;
      b.bin = 10'(m_bin);
      if (m_bin == m_pts - 1) begin
        m_in_frame = 0;
        if (!sink_eop) begin
          viol  = 1;
          b.eop = 1'b1;
        end
      end else if (sink_eop) begin
        viol = 1;
        m_in_frame = 0;
      end
      m_bin++;
    end
    if (fwd) expq.push_back(b);
    m_ferr = viol;
    if (viol && m_cnt < 255) m_cnt++;
  endtask

  int cyc = 0;
  always @(posedge clk) cyc++;

  bit rand_ready = 0;
  always @(posedge clk) begin
    #1;
    source_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  bit          prev_stall = 0, lat_arm = 0;
  logic [78:0] held;
  int          consumed = 0, acc_cyc = -1, out_cyc = -1;
  logic [31:0] last_p_def, last_p0, sop_p_def, sop_p0;
  logic [9:0]  last_bin;
  logic        last_eop;

  always @(negedge clk) begin
    if (reset) begin
      expq.delete();
      m_in_frame = 0;
      m_cnt      = 0;
      m_ferr     = 0;
      prev_stall = 0;
    end else begin
      chk("sink_ready", sink_ready, !source_valid || source_ready);
      chk("valid_match", source_valid_z, source_valid);
      chk("frame_err", frame_err, m_ferr);
      chk("err_count", err_count, m_cnt);
      if (prev_stall)
        chk("stall_hold", {source_valid, source_sop, source_eop, source_error, source_bin,
                           source_power, source_power_z}, held);
      if (source_valid && lat_arm && out_cyc < 0) out_cyc = cyc;
      if (source_valid && source_ready) begin
        if (expq.size() == 0) begin
          chk("unexpected_beat", source_valid, 1'b0);
        end else begin
          beat_t e;
          e = expq.pop_front();
          chk("beat_sop", source_sop, e.sop);
          chk("beat_eop", source_eop, e.eop);
          chk("beat_err", source_error, e.err);
          chk("beat_bin", source_bin, e.bin);
          chk("beat_power", source_power, e.p_def);
          chk("beat_power_s0", source_power_z, e.p_s0);
        end
        consumed++;
        last_p_def = source_power;
        last_p0    = source_power_z;
        last_bin   = source_bin;
        last_eop   = source_eop;
        if (source_sop) begin
          sop_p_def = source_power;
          sop_p0    = source_power_z;
        end
      end
      prev_stall = source_valid && !source_ready;
      held = {source_valid, source_sop, source_eop, source_error, source_bin,
              source_power, source_power_z};
      m_ferr = 0;
      if (sink_valid && sink_ready) begin
        if (lat_arm && acc_cyc < 0) acc_cyc = cyc;
        model_accept();
      end
    end
  end

  task automatic send(input bit sop, input bit eop, input logic signed [28:0] re,
                      input logic signed [28:0] im, input logic [10:0] pts,
                      input logic [1:0] err);
    int n = 0;
    bit a;
    sink_valid = 1'b1;
    sink_sop   = sop;
    sink_eop   = eop;
    sink_real  = re;
    sink_imag  = im;
    fftpts_in  = pts;
    sink_error = err;
    do begin
      @(negedge clk);
      a = sink_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!a && n < 1000);
    if (!a) chk("send_timeout", a, 1'b1);
    sink_valid = 1'b0;
    sink_sop   = 1'b0;
    sink_eop   = 1'b0;
  endtask

  // mode 0: re=3, im=4; mode 1: random data
  task automatic send_frame(input int pts, input int nbeats, input bit eop_last, input int mode);
    logic signed [28:0] re, im;
    for (int i = 0; i < nbeats; i++) begin
      re = (mode == 0) ? 29'sd3 : 29'($urandom);
      im = (mode == 0) ? 29'sd4 : 29'($urandom);
      send(i == 0, eop_last && (i == nbeats - 1), re, im, 11'(pts), 2'(i));
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((expq.size() != 0 || source_valid) && n < 5000) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain", expq.size(), 0);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #800us;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  int c0;

  initial begin
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", source_valid, 1'b0);
    chk("rst_sop", source_sop, 1'b0);
    chk("rst_eop", source_eop, 1'b0);
    chk("rst_frame_err", frame_err, 1'b0);
    chk("rst_power", source_power, 32'd0);
    chk("rst_bin", source_bin, 10'd0);
    chk("rst_error", source_error, 2'd0);
    chk("rst_err_count", err_count, 8'd0);
    chk("rst_sink_ready", sink_ready, 1'b1);
    reset = 1'b0;
    idle(2);

    // 64-point frame of 3+4j: power 25 unscaled, 0 at SHIFT=26
    c0 = consumed;
    lat_arm = 1;
    send_frame(64, 64, 1, 0);
    drain();
    lat_arm = 0;
    chk("t1_latency", out_cyc - acc_cyc, 3);
    chk("t1_count", consumed - c0, 64);
    chk("t1_p_s0", last_p0, 32'd25);
    chk("t1_p_def", last_p_def, 32'd0);
    chk("t1_last_bin", last_bin, 10'd63);
    chk("t1_last_eop", last_eop, 1'b1);

    // Most negative input on bin 0: P = 2^57
    send(1, 0, 29'sh1000_0000, 29'sh1000_0000, 11'd64, 2'd0);
    for (int i = 1; i < 64; i++) send(0, i == 63, 29'sd3, 29'sd4, 11'd64, 2'd0);
    drain();
    chk("t2_p_def", sop_p_def, 32'h8000_0000);
    chk("t2_p_s0_sat", sop_p0, 32'hFFFF_FFFF);

    // 1024-point frame under random backpressure
    c0 = consumed;
    rand_ready = 1;
    send_frame(1024, 1024, 1, 1);
    drain();
    rand_ready = 0;
    idle(2);
    chk("t3_count", consumed - c0, 1024);
    chk("t3_last_bin", last_bin, 10'd1023);

    // Non-sop beat while idle is dropped and flagged
    c0 = consumed;
    send(0, 0, 29'sd5, 29'sd6, 11'd64, 2'd0);
    idle(5);
    chk("t4_err_count", err_count, 8'd1);
    chk("t4_dropped", consumed - c0, 0);

    // Early eop at bin 100 of a 256-point frame
    send_frame(256, 101, 1, 1);
    drain();
    chk("t5_err_count", err_count, 8'd2);
    chk("t5_early_bin", last_bin, 10'd100);
    c0 = consumed;
    send_frame(64, 64, 1, 0);
    drain();
    chk("t5_restart_count", consumed - c0, 64);
    chk("t5_err_count_clean", err_count, 8'd2);

    // Missing eop at bin 255: eop forced on the output
    send_frame(256, 256, 0, 1);
    drain();
    chk("t5_forced_eop", last_eop, 1'b1);
    chk("t5_forced_bin", last_bin, 10'd255);
    chk("t5_err_count_miss", err_count, 8'd3);

    // Reset with beats in flight
    send_frame(64, 10, 0, 0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("t6_valid_after_rst", source_valid, 1'b0);
    chk("t6_err_count_after_rst", err_count, 8'd0);
    idle(1);
    reset = 1'b0;
    idle(2);
    c0 = consumed;
    send_frame(64, 64, 1, 1);
    drain();
    chk("t6_clean_count", consumed - c0, 64);
    chk("t6_clean_err_count", err_count, 8'd0);
    chk("t6_clean_eop", last_eop, 1'b1);

    idle(3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fft_bin_power.md
# fft_bin_power

Streaming power-spectrum stage directly downstream of the variable-size FFT core. Consumes the core's Avalon-ST output frames (29-bit signed real/imag per bin) and emits one unsigned power value per bin, `re² + im²`, scaled and saturated to `OUT_W` bits, tagged with its bin index. Framing (`sop`/`eop`) and backpressure pass through. Malformed frames are flagged and counted, never propagated silently.

## Interface
- `IN_W`, 29, width of the signed real/imag inputs.
- `OUT_W`, 32, width of the unsigned power output.
- `SHIFT`, 26, right shift applied to the full `2*IN_W`-bit sum before saturation.
- `clk  in  1`, single clock.
- `reset  in  1`, synchronous, active-high.
- `sink_valid  in  1`, input beat valid.
- `sink_ready  out  1`, input beat accepted when `sink_valid & sink_ready`.
- `sink_error  in  2`, FFT core error code; travels with the beat.
- `sink_sop` / `sink_eop`  in  1 each, frame start / end.
- `sink_real` / `sink_imag`  in  `IN_W` each, signed two's complement.
- `fftpts_in  in  11`, frame length, one of 64..1024 (power of two); sampled on the accepted sop beat only.
- `source_valid  out  1`, output beat valid.
- `source_ready  in  1`, downstream ready.
- `source_sop` / `source_eop`  out  1 each, frame markers aligned with the data.
- `source_error  out  2`, `sink_error` delayed with its beat.
- `source_power  out  OUT_W`, scaled power.
- `source_bin  out  10`, bin index within the frame.
- `frame_err  out  1`, one-cycle pulse per framing violation.
- `err_count  out  8`, saturating count of framing violations.

## Operation
- Full-precision sum is `P = re*re + im*im`, `2*IN_W` bits unsigned. Squares are computed signed; `(-2^(IN_W-1))²` must be exact.
- Output is `P >> SHIFT`. If any bit of the shifted value above `OUT_W-1` is set, the output is forced to `2^OUT_W - 1`. With the defaults this never saturates.
- Frame FSM, states IDLE and IN_FRAME:
  - IDLE, accepted sop: latch `fftpts_in`, bin = 0, forward the beat. Go to IN_FRAME, or stay in IDLE if `eop` is also set (1-beat frame, flagged).
  - IDLE, accepted non-sop beat: drop it (not forwarded) and raise `frame_err`.
  - IN_FRAME, accepted beat: bin increments and the beat is forwarded.
  - IN_FRAME, sop: `frame_err`, then restart at bin 0 with a new `fftpts` latch.
  - IN_FRAME, eop at bin ≠ fftpts−1: `frame_err`, return to IDLE.
  - IN_FRAME, beat at bin = fftpts−1 without eop: `frame_err`, forward the beat with `source_eop` forced high, return to IDLE.
- Forwarded beats carry their own sop/eop/error. Only the forced-eop case above alters a marker.
- `err_count` increments once per violation and saturates at 255. Only `reset` clears it.

## Timing
- 3-stage pipeline: S1 squares, S2 sum, S3 shift/saturate plus output registers. Latency from accepted input to `source_valid` is 3 cycles with no stalls.
- Global-stall pipeline: `adv = !source_valid | source_ready`, and `sink_ready = adv`. This is a combinational `source_ready`→`sink_ready` path, permitted by design. Bubbles do not collapse.
- While `source_valid & !source_ready`, all output signals hold stable.
- Throughput is 1 beat/cycle with `source_ready` held high.
- `frame_err` is registered and pulses the cycle after the offending accept.
- Reset values: `source_valid`, `source_sop`, `source_eop`, `frame_err` = 0; `source_power`, `source_bin`, `source_error`, `err_count` = 0; `sink_ready` = 1. FSM goes to IDLE and all pipeline valids clear.
- Reset mid-frame discards in-flight beats. The next frame must start with sop.

## Structure
- Shared package `fft_pkg`: `FFTPTS_W = 11`, `BIN_W = 10`, Avalon error code constants, FSM state enum.
- One sub-module, `fft_bin_power_sq`: a 2-stage signed square-and-sum with clock enable. Frame FSM, counter and output stage live in the top.

## Test plan
- 64-point frame, all bins `re = 3, im = 4`, `SHIFT = 0`, `OUT_W = 32`, ready high → 64 beats of power 25, bins 0..63, sop on bin 0, eop on bin 63, first output 3 cycles after first accept.
- `re = im = -2^28`, defaults → `P = 2^57`, output `2^31`. With `SHIFT = 0` the output saturates to `0xFFFFFFFF`.
- 1024-point frame with random `source_ready` (50 %) → all 1024 beats in order, no loss or duplication, outputs stable while stalled.
- Non-sop beat in IDLE → no output, `frame_err` pulse, `err_count = 1`.
- 256-point frame, eop at bin 100 → `frame_err`. Next sop restarts bin at 0. Separate case: missing eop at bin 255 → output eop forced, `err_count` increments.
- Reset asserted mid-frame with 3 beats in flight → `source_valid` = 0 the next cycle, `err_count = 0`. A subsequent clean 64-point frame passes intact.
